// File: rtl/eigen_reconstruct.sv
// Rebuilds a symmetric SIZE_N x SIZE_N matrix from its eigenpairs,
// A = sum_k lambda_k * v_k * v_k^T. Eigenpairs are captured on start, each
// element is formed with one serial MAC term per cycle, and elements are
// streamed out row-major over a valid/ready handshake.
module eigen_reconstruct #(
  parameter  int SIZE_N = 8,
  parameter  int DATA_W = 32,
  parameter  int FRAC_W = 16,
  localparam int IDX_W  = $clog2(SIZE_N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SIZE_N*SIZE_N*DATA_W-1:0] vec_in,
  input  logic [SIZE_N*DATA_W-1:0]   val_in,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_row,
  output logic [IDX_W-1:0]           out_col,
  output logic                       out_last,
  output logic                       done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e                     state_q, state_d;
  logic signed [DATA_W-1:0]   vec_q [SIZE_N][SIZE_N];
  logic signed [DATA_W-1:0]   vec_d [SIZE_N][SIZE_N];
  logic signed [DATA_W-1:0]   val_q [SIZE_N];
  logic signed [DATA_W-1:0]   val_d [SIZE_N];
  logic [IDX_W-1:0]           row_q, row_d, col_q, col_d, k_q, k_d;
  logic signed [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]          out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic                       done_q, done_d;

  // MAC term for the current (row, col, k) and the saturated running sum
  logic signed [DATA_W-1:0]   va, vb, lam, p1;
  logic signed [2*DATA_W-1:0] prod_vv, prod_pl, p2, acc_sum;
  logic [DATA_W-1:0]          sat_val;
  logic                       xfer;

  // Arithmetic for one term: two Q-format products with floor shifts
  always_comb begin
    va      = vec_q[k_q][row_q];
    vb      = vec_q[k_q][col_q];
    lam     = val_q[k_q];
    prod_vv = va * vb;
    p1      = DATA_W'(prod_vv >>> FRAC_W);
    prod_pl = p1 * lam;
    p2      = prod_pl >>> FRAC_W;
    acc_sum = acc_q + p2;
    if ((acc_sum[2*DATA_W-1:DATA_W-1] == '0) || (acc_sum[2*DATA_W-1:DATA_W-1] == '1)) begin
      sat_val = acc_sum[DATA_W-1:0];
    end else if (acc_sum[2*DATA_W-1]) begin
      sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  assign xfer = (state_q == S_OUT) && out_valid_q && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start)         state_d = S_MAC;
      S_MAC:  if (k_q == LAST_IDX) state_d = S_OUT;
      S_OUT:  if (xfer)          state_d = out_last_q ? S_IDLE : S_MAC;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture, MAC accumulate, element load and advance
  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    vec_d       = vec_q;
    val_d       = val_q;
    row_d       = row_q;
    col_d       = col_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < SIZE_N; k++) begin
            val_d[k] = val_in[k*DATA_W +: DATA_W];
            for (int i = 0; i < SIZE_N; i++) begin
              vec_d[k][i] = vec_in[(k*SIZE_N+i)*DATA_W +: DATA_W];
            end
          end
          row_d = '0;
          col_d = '0;
          k_d   = '0;
          acc_d = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + IDX_W'(1);
        if (k_q == LAST_IDX) begin
          out_data_d  = sat_val;
          out_valid_d = 1'b1;
          out_last_d  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        end
      end
      S_OUT: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            done_d = 1'b1;
          end else begin
            k_d   = '0;
            acc_d = '0;
            if (col_q == LAST_IDX) begin
              col_d = '0;
              row_d = row_q + IDX_W'(1);
            end else begin
              col_d = col_q + IDX_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the captured eigenpair array is reset too, so nothing from a prior run survives reset.
      for (int k = 0; k < SIZE_N; k++) begin
        val_q[k] <= '0;
        for (int i = 0; i < SIZE_N; i++) vec_q[k][i] <= '0;
      end
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      vec_q       <= vec_d;
      val_q       <= val_d;
      row_q       <= row_d;
      col_q       <= col_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Outputs: all registered except busy, which decodes the state register
  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_row   = row_q;
    out_col   = col_q;
    out_last  = out_last_q;
    done      = done_q;
  end

endmodule
